// File: rtl/word_block_packer.sv
// Gathers N = BSIZE/WSIZE words from a FWFT word FIFO into one block, with an
// optional flush that pads a partial block and tags it as the last one.
module word_block_packer #(
    parameter int                WSIZE      = 32,
    parameter int                BSIZE      = 128,
    parameter int                WORD_ORDER = 0,
    parameter logic [WSIZE-1:0]  PAD_WORD   = {WSIZE{1'b0}},
    localparam int               N          = BSIZE / WSIZE,
    localparam int               CW         = $clog2(N) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WSIZE-1:0] word_in,
    input  logic             word_in_ready,
    output logic             pull_word,
    input  logic             flush_in,
    input  logic             block_out_hold,
    output logic [BSIZE-1:0] block_out,
    output logic             block_ready,
    output logic [CW-1:0]    block_words,
    output logic             block_last,
    output logic [CW-1:0]    words_held
);

    if ((BSIZE % WSIZE) != 0 || (BSIZE / WSIZE) < 2 || (WORD_ORDER != 0 && WORD_ORDER != 1))
    begin : g_bad_params
        $error("word_block_packer: BSIZE must hold at least two whole words and WORD_ORDER must be 0 or 1");
    end

    typedef enum logic {FILL, EMIT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    fill_cnt;
    logic [BSIZE-1:0] asm_q;
    logic [BSIZE-1:0] asm_next;
    logic [BSIZE-1:0] closed_blk;
    logic             flush_pend;
    logic             flush_now;
    logic             close_now;

    // Bit offset of slot k; order 0 puts the first word in the MSBs.
    function automatic int slot_lo(input int k);
        return (WORD_ORDER == 0) ? (BSIZE - (k + 1) * WSIZE) : (k * WSIZE);
    endfunction

    assign pull_word   = ~reset & (state == FILL) & word_in_ready;
    assign block_ready = ~reset & (state == EMIT) & ~block_out_hold;
    assign words_held  = (state == FILL) ? cnt : '0;
    assign flush_now   = flush_in | flush_pend;
    assign close_now   = (fill_cnt == CW'(N)) || (flush_now && (fill_cnt != '0));

    // fill_cnt is the count including this cycle's pull; slots at or past it get the pad.
    always_comb begin
        asm_next = asm_q;
        fill_cnt = cnt;
        if (pull_word) begin
            asm_next[slot_lo(int'(cnt)) +: WSIZE] = word_in;
            fill_cnt = cnt + CW'(1);
        end
        closed_blk = asm_next;
        for (int k = 0; k < N; k++) begin
            if (CW'(k) >= fill_cnt) begin
                closed_blk[slot_lo(k) +: WSIZE] = PAD_WORD;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FILL;
            cnt         <= '0;
            flush_pend  <= 1'b0;
            asm_q       <= '0;
            block_out   <= '0;
            block_words <= '0;
            block_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    flush_pend <= 1'b0;
                    if (close_now) begin
                        block_out   <= closed_blk;
                        block_words <= fill_cnt;
                        block_last  <= flush_now;
                        state       <= EMIT;
                    end else begin
                        cnt   <= fill_cnt;
                        asm_q <= asm_next;
                    end
                end
                EMIT: begin
                    // A flush seen while a block waits is replayed on the first FILL cycle.
                    if (flush_in) begin
                        flush_pend <= 1'b1;
                    end
                    if (!block_out_hold) begin
                        state <= FILL;
                        cnt   <= '0;
                        asm_q <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
